laser_search_ctrl: RTL
======================

# laser_search_ctrl

Sequencing controller for the LASER two-circle coverage engine. It captures a 40-point frame streamed one point per cycle on X/Y into an internal point buffer. It then schedules an alternating exhaustive sweep: C1 is optimised with C2 fixed, then C2 with C1 fixed. Each pass steps one (candidate, point) pair per cycle through a radius-4 coverage check, and the block reports the two centres with a one-cycle DONE.

## Interface
- N_PT, 40: points per frame; sets buffer depth and load length.
- MAX_PASS, 8: hard limit on sweep passes per frame.
- R_SQ, 16: coverage threshold. A point is covered when dx²+dy² ≤ R_SQ.
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  synchronous, active-high reset.
- X  in  4  point x coordinate; sampled only in LOAD.
- Y  in  4  point y coordinate; sampled only in LOAD.
- C1X  out  4  centre 1 x; registered.
- C1Y  out  4  centre 1 y; registered.
- C2X  out  4  centre 2 x; registered.
- C2Y  out  4  centre 2 y; registered.
- DONE  out  1  result-valid pulse; registered.

## Operation
- States: LOAD → SEARCH → UPDATE → (SEARCH | FINISH) → LOAD.
- LOAD
  - Each cycle with RST low, write (X,Y) to buf[ld_cnt] and increment ld_cnt.
  - After N_PT captures, go to SEARCH with pass=0, side=C1, cand=0, pt=0, best_cnt=0, upd=0.
  - cur_cov is cleared to 0 at the start of each frame.
- SEARCH: evaluates one (cand, pt) pair per cycle.
  - cand is 8 bits {cy,cx}, raster order with y outer, so cand=0 is (0,0) and cand=1 is (1,0).
  - pt runs 0..N_PT-1 inside each candidate.
  - hit = covered(cand, buf[pt]) OR covered(fixed centre, buf[pt]). The fixed centre is C2 when side=C1, otherwise C1.
  - acc increments on hit; acc is 6 bits and saturation is not needed.
  - At pt=N_PT-1, the final acc (including this point) is compared with best_cnt. On strictly greater, set best_cnt=acc and best_xy=cand. acc then clears.
  - Ties keep the earlier raster candidate.
- Distance arithmetic:
  - dx=|cx-px| and dy=|cy-py|, each 4-bit unsigned.
  - Squares are 8 bits; their sum is 9 bits, compared unsigned against R_SQ.
- SEARCH → UPDATE after cand=255, pt=N_PT-1.
- UPDATE (one cycle)
  - If best_cnt > cur_cov: the swept centre output takes best_xy, cur_cov=best_cnt, noupd_run=0.
  - Otherwise noupd_run increments.
  - Then pass increments, side toggles, and cand, pt, best_cnt reset to 0.
  - Go to FINISH if noupd_run reaches 2 (including this pass) or pass reaches MAX_PASS; else go to SEARCH.
- FINISH: DONE=1 for exactly one cycle, then LOAD with ld_cnt=0. Capture of point 0 of the next frame is the following cycle.
- Outputs hold their values from FINISH until the next UPDATE that changes them, or until reset.
- At the start of each new frame, C1/C2 working centres restart at (0,0). The output registers keep showing the previous result until that frame's first update.
- X/Y are ignored outside LOAD.

## Timing
- Reset values: C1X=C1Y=C2X=C2Y=0, DONE=0, state=LOAD, ld_cnt=0, all counters 0.
- RST is honoured in any state, including mid-LOAD and mid-SEARCH; the frame is abandoned.
- First capture happens in the first cycle with RST low. Cycle 0 is defined as that capture.
- LOAD occupies cycles 0..N_PT-1.
- Each pass lasts 256·N_PT SEARCH cycles plus 1 UPDATE cycle: 10241 cycles at defaults.
- DONE is high in cycle N_PT + P·10241, where P is the number of passes executed.
- DONE is never asserted in LOAD or SEARCH. DONE is never X after reset.
- Minimum run is 2 passes, maximum MAX_PASS passes.

## Test plan
- All 40 points at (5,5):
  - Pass 1 sets C1=(5,1), cur_cov=40; passes 2 and 3 make no update.
  - Expect C1=(5,1), C2=(0,0), DONE in cycle 30763.
- 20 points at (15,0) and 20 at (0,15):
  - Pass 1 sets C1=(11,0) with 20 covered; pass 2 sets C2=(0,11) with 40 covered; passes 3 and 4 make no update.
  - Expect C1=(11,0), C2=(0,11), DONE in cycle 41004.
- Same pattern as scenario 2 with MAX_PASS=2: C1=(11,0), C2=(0,11), DONE in cycle 20522.
- Tie ordering, 20 points at (2,2) and 20 at (12,12):
  - C1=(12,8) with 40 covered, because fixed C2=(0,0) already covers the (2,2) cluster.
  - Expect C2=(0,0), DONE in cycle 30763.
- Back-to-back frames: scenario 1 frame followed immediately, with no reset, by scenario 2 frame.
  - Second frame's point 0 is captured in the cycle after DONE.
  - Outputs hold (5,1)/(0,0) until the second frame's first UPDATE.
  - Second DONE is 41005 cycles after the first.
- RST pulsed for 1 cycle mid-pass 2 of scenario 2:
  - The cycle after the reset edge: all outputs 0 and DONE 0.
  - A fresh scenario 1 frame then completes exactly as in scenario 1.

Source files
------------

// File: rtl/laser_search_ctrl.sv
// laser_search_ctrl: loads a point frame, then alternates exhaustive sweeps
// of centre 1 and centre 2 over a 16x16 grid to maximise radius coverage.
// Ports: CLK, RST (sync, active-high); X/Y point stream sampled in LOAD;
// C1X/C1Y/C2X/C2Y registered centres; DONE one-cycle result pulse.
module laser_search_ctrl #(
    parameter int N_PT     = 40,
    parameter int MAX_PASS = 8,
    parameter int R_SQ     = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic       DONE
);
    localparam int PT_W   = $clog2(N_PT);
    localparam int CNT_W  = $clog2(N_PT + 1);
    localparam int PASS_W = $clog2(MAX_PASS + 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SEARCH,
        S_UPDATE,
        S_FINISH
    } state_t;

    state_t state_q, state_d;

    logic [PT_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              side_q, side_d;
    logic [7:0]        cand_q, cand_d;
    logic [PT_W-1:0]   pt_q, pt_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
    logic [7:0]        best_xy_q, best_xy_d;
    logic [CNT_W-1:0]  cur_cov_q, cur_cov_d;
    logic [1:0]        noupd_q, noupd_d;
    // Working centres and output centres, packed {y,x}
    logic [7:0]        w1_q, w1_d;
    logic [7:0]        w2_q, w2_d;
    logic [7:0]        o1_q, o1_d;
    logic [7:0]        o2_q, o2_d;
    logic              done_q, done_d;

    logic [3:0] bx_q [N_PT];
    logic [3:0] bx_d [N_PT];
    logic [3:0] by_q [N_PT];
    logic [3:0] by_d [N_PT];

    function automatic logic covered(
        input logic [3:0] ax,
        input logic [3:0] ay,
        input logic [3:0] px,
        input logic [3:0] py
    );
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sx;
        logic [7:0] sy;
        logic [8:0] sum;
        dx  = (ax >= px) ? ax - px : px - ax;
        dy  = (ay >= py) ? ay - py : py - ay;
        sx  = 8'(dx) * 8'(dx);
        sy  = 8'(dy) * 8'(dy);
        sum = 9'(sx) + 9'(sy);
        return sum <= 9'(R_SQ);
    endfunction

    logic [3:0]       cur_px;
    logic [3:0]       cur_py;
    logic [7:0]       fixed_xy;
    logic             hit;
    logic [CNT_W-1:0] acc_inc;

    always_comb begin
        cur_px   = bx_q[pt_q];
        cur_py   = by_q[pt_q];
        // The centre not being swept stays fixed for this pass
        fixed_xy = side_q ? w1_q : w2_q;
        hit      = covered(cand_q[3:0], cand_q[7:4], cur_px, cur_py)
                 | covered(fixed_xy[3:0], fixed_xy[7:4], cur_px, cur_py);
        acc_inc  = acc_q + CNT_W'(hit);
    end

    always_comb begin
        bx_d = bx_q;
        by_d = by_q;
        if (state_q == S_LOAD) begin
            bx_d[ld_cnt_q] = X;
            by_d[ld_cnt_q] = Y;
        end
    end

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        pass_d     = pass_q;
        side_d     = side_q;
        cand_d     = cand_q;
        pt_d       = pt_q;
        acc_d      = acc_q;
        best_cnt_d = best_cnt_q;
        best_xy_d  = best_xy_q;
        cur_cov_d  = cur_cov_q;
        noupd_d    = noupd_q;
        w1_d       = w1_q;
        w2_d       = w2_q;
        o1_d       = o1_q;
        o2_d       = o2_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                ld_cnt_d = ld_cnt_q + PT_W'(1);
                if (ld_cnt_q == PT_W'(N_PT - 1)) begin
                    state_d    = S_SEARCH;
                    ld_cnt_d   = '0;
                    pass_d     = '0;
                    side_d     = 1'b0;
                    cand_d     = '0;
                    pt_d       = '0;
                    acc_d      = '0;
                    best_cnt_d = '0;
                    best_xy_d  = '0;
                    cur_cov_d  = '0;
                    noupd_d    = '0;
                    w1_d       = '0;
                    w2_d       = '0;
                end
            end
            S_SEARCH: begin
                if (pt_q == PT_W'(N_PT - 1)) begin
                    pt_d  = '0;
                    acc_d = '0;
                    // Strict compare keeps the earliest raster candidate on ties
                    if (acc_inc > best_cnt_q) begin
                        best_cnt_d = acc_inc;
                        best_xy_d  = cand_q;
                    end
                    cand_d = cand_q + 8'd1;
                    if (cand_q == 8'hFF) begin
                        state_d = S_UPDATE;
                    end
                end else begin
                    pt_d  = pt_q + PT_W'(1);
                    acc_d = acc_inc;
                end
            end
            S_UPDATE: begin
                if (best_cnt_q > cur_cov_q) begin
                    cur_cov_d = best_cnt_q;
                    noupd_d   = '0;
                    if (side_q) begin
                        w2_d = best_xy_q;
                        o1_d = w1_q;
                        o2_d = best_xy_q;
                    end else begin
                        w1_d = best_xy_q;
                        o1_d = best_xy_q;
                        o2_d = w2_q;
                    end
                end else begin
                    noupd_d = noupd_q + 2'd1;
                end
                pass_d     = pass_q + PASS_W'(1);
                side_d     = ~side_q;
                cand_d     = '0;
                pt_d       = '0;
                acc_d      = '0;
                best_cnt_d = '0;
                if (noupd_d == 2'd2 || pass_d == PASS_W'(MAX_PASS)) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_SEARCH;
                end
            end
            S_FINISH: begin
                state_d  = S_LOAD;
                ld_cnt_d = '0;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        bx_q <= bx_d;
        by_q <= by_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_LOAD;
            ld_cnt_q   <= '0;
            pass_q     <= '0;
            side_q     <= 1'b0;
            cand_q     <= '0;
            pt_q       <= '0;
            acc_q      <= '0;
            best_cnt_q <= '0;
            best_xy_q  <= '0;
            cur_cov_q  <= '0;
            noupd_q    <= '0;
            w1_q       <= '0;
            w2_q       <= '0;
            o1_q       <= '0;
            o2_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            pass_q     <= pass_d;
            side_q     <= side_d;
            cand_q     <= cand_d;
            pt_q       <= pt_d;
            acc_q      <= acc_d;
            best_cnt_q <= best_cnt_d;
            best_xy_q  <= best_xy_d;
            cur_cov_q  <= cur_cov_d;
            noupd_q    <= noupd_d;
            w1_q       <= w1_d;
            w2_q       <= w2_d;
            o1_q       <= o1_d;
            o2_q       <= o2_d;
            done_q     <= done_d;
        end
    end

    assign C1X  = o1_q[3:0];
    assign C1Y  = o1_q[7:4];
    assign C2X  = o2_q[3:0];
    assign C2Y  = o2_q[7:4];
    assign DONE = done_q;

endmodule
